// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and helpers for the NxN matrix-multiply stream
//                engine: controller state encoding and accumulator width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CALC  = 2'd2,
      ST_DRAIN = 2'd3
   } mm_state_t;

   // Width that holds the sum of n full-width products without overflow.
   function automatic int acc_width(input int data_w, input int n);
      return 2 * data_w + $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mm_nxn_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : mm_nxn_stream_if
//  Description : Valid/ready stream bundle with last marker. The engine uses
//                one instance as its input (slave) and one as its output
//                (master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mm_nxn_stream_if #(
   parameter int pDATA_WIDTH = 32
);
   logic                   tvalid;
   logic                   tready;
   logic [pDATA_WIDTH-1:0] tdata;
   logic                   tlast;

   modport master (output tvalid, output tdata, output tlast, input  tready);
   modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/mm_dot.sv
`default_nettype none
// ============================================================================
//  Module      : mm_dot
//  Description : Combinational pN-term dot product. Products are full
//                2*pDATA_WIDTH wide and the sum is widened so no term or
//                partial sum can overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_dot
   import mm_pkg::*;
#(
   parameter int pN          = 4,
   parameter int pDATA_WIDTH = 32
) (
   input  logic [pDATA_WIDTH-1:0]                  i_a [pN],
   input  logic [pDATA_WIDTH-1:0]                  i_b [pN],
   output logic [acc_width(pDATA_WIDTH, pN)-1:0]   o_sum
);

   localparam int c_ACC_W = acc_width(pDATA_WIDTH, pN);

   logic [2*pDATA_WIDTH-1:0] w_prod [pN];

   genvar k;
   generate
      for (k = 0; k < pN; k++) begin : g_mul
         assign w_prod[k] = {{pDATA_WIDTH{1'b0}}, i_a[k]} * {{pDATA_WIDTH{1'b0}}, i_b[k]};
      end
   endgenerate

   // Sum all products; written as a chain, the synthesiser balances it into a tree.
   always_comb begin
      o_sum = '0;
      for (int i = 0; i < pN; i++) begin
         o_sum = o_sum + c_ACC_W'(w_prod[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mm_nxn_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mm_nxn_stream
//  Description : Streaming NxN matrix multiplier. Loads A then B (row-major)
//                from the input stream, computes one C element per cycle,
//                then drains C (row-major) on the output stream.
//                Optional build macro MM_SAT_EN: saturate each C element to
//                the element width instead of keeping the low bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_nxn_stream
   import mm_pkg::*;
#(
   parameter int pDATA_WIDTH = 32,
   parameter int pN          = 4
) (
   input  logic            clk,
   input  logic            rst,
   mm_nxn_stream_if.slave  ss,
   mm_nxn_stream_if.master sm,
   output logic            busy,
   output logic            err
);

   localparam int                c_RW    = $clog2(pN);
   localparam int                c_ACC_W = acc_width(pDATA_WIDTH, pN);
   localparam logic [c_RW-1:0]   c_LAST  = c_RW'(pN - 1);

   mm_state_t                r_state;
   mm_state_t                w_state_nxt;
   logic [c_RW-1:0]          r_row;
   logic [c_RW-1:0]          r_col;
   logic                     r_sel;      // 0 while loading A, 1 while loading B
   logic                     r_err;

   logic [pDATA_WIDTH-1:0]   r_a [pN][pN];
   logic [pDATA_WIDTH-1:0]   r_b [pN][pN];
   logic [pDATA_WIDTH-1:0]   r_c [pN][pN];

   logic [pDATA_WIDTH-1:0]   w_dot_a [pN];
   logic [pDATA_WIDTH-1:0]   w_dot_b [pN];
   logic [c_ACC_W-1:0]       w_sum;
   logic [pDATA_WIDTH-1:0]   w_c_elem;

   logic                     w_accept;
   logic                     w_at_end;
   logic                     w_last_beat;
   logic                     w_step;

   assign w_accept    = ss.tvalid & ss.tready;
   assign w_at_end    = (r_row == c_LAST) && (r_col == c_LAST);
   assign w_last_beat = r_sel & w_at_end;
   assign w_step      = ((r_state == ST_LOAD)  && w_accept)  ||
                        (r_state == ST_CALC)                 ||
                        ((r_state == ST_DRAIN) && sm.tready);

   assign busy = (r_state != ST_IDLE);
   assign err  = r_err;

   // Row i of A and column j of B feed the dot-product unit during CALC.
   genvar k;
   generate
      for (k = 0; k < pN; k++) begin : g_oper
         assign w_dot_a[k] = r_a[r_row][k];
         assign w_dot_b[k] = r_b[k][r_col];
      end
   endgenerate

   mm_dot #(
      .pN          (pN),
      .pDATA_WIDTH (pDATA_WIDTH)
   ) u_dot (
      .i_a   (w_dot_a),
      .i_b   (w_dot_b),
      .o_sum (w_sum)
   );

`ifdef MM_SAT_EN
   assign w_c_elem = (|w_sum[c_ACC_W-1:pDATA_WIDTH]) ? {pDATA_WIDTH{1'b1}}
                                                    : w_sum[pDATA_WIDTH-1:0];
`else
   // Wrap-around: the high bits of the sum are intentionally dropped.
   logic w_unused_hi;
   assign w_unused_hi = |w_sum[c_ACC_W-1:pDATA_WIDTH];
   assign w_c_elem    = w_sum[pDATA_WIDTH-1:0];
`endif

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and stream handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      ss.tready   = 1'b0;
      sm.tvalid   = 1'b0;
      sm.tdata    = '0;
      sm.tlast    = 1'b0;
      case (r_state)
         ST_IDLE:  w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            ss.tready = 1'b1;
            if (w_accept && w_last_beat) w_state_nxt = ST_CALC;
         end
         ST_CALC: begin
            if (w_at_end) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            sm.tvalid = 1'b1;
            sm.tdata  = r_c[r_row][r_col];
            sm.tlast  = w_at_end;
            if (sm.tready && w_at_end) w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Shared row/column walker; wraps to zero at the end of each phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
         r_sel <= 1'b0;
      end else if (w_step) begin
         if (r_col == c_LAST) begin
            r_col <= '0;
            if (r_row == c_LAST) begin
               r_row <= '0;
               r_sel <= (r_state == ST_LOAD) ? ~r_sel : 1'b0;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Matrix storage; every job overwrites all entries before they are read.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         if (r_sel) r_b[r_row][r_col] <= ss.tdata;
         else       r_a[r_row][r_col] <= ss.tdata;
      end
      if (r_state == ST_CALC) begin
         r_c[r_row][r_col] <= w_c_elem;
      end
   end

   // Sticky framing error: tlast must mark exactly the final B beat.
   always_ff @(posedge clk) begin
      if (rst)                                     r_err <= 1'b0;
      else if (w_accept && (ss.tlast != w_last_beat)) r_err <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_mm_nxn_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_nxn_stream
//  Description : Directed self-checking bench for mm_nxn_stream at pN=4 and
//                pN=2 with hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_nxn_stream;

   logic clk;
   logic rst;
   logic busy4, err4, busy2, err2;

   mm_nxn_stream_if #(.pDATA_WIDTH(32)) ss4();
   mm_nxn_stream_if #(.pDATA_WIDTH(32)) sm4();
   mm_nxn_stream_if #(.pDATA_WIDTH(32)) ss2();
   mm_nxn_stream_if #(.pDATA_WIDTH(32)) sm2();

   mm_nxn_stream #(.pDATA_WIDTH(32), .pN(4)) u_dut4 (
      .clk (clk), .rst (rst), .ss (ss4), .sm (sm4), .busy (busy4), .err (err4)
   );

   mm_nxn_stream #(.pDATA_WIDTH(32), .pN(2)) u_dut2 (
      .clk (clk), .rst (rst), .ss (ss2), .sm (sm2), .busy (busy2), .err (err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] a_v [16];
   logic [31:0] b_v [16];
   logic [31:0] e_v [16];
   logic [31:0] v2  [8];
   logic [31:0] e2  [4];
   int          got2, cyc2;

`ifdef MM_SAT_EN
   localparam logic [31:0] c_FULL_EXP = 32'hFFFF_FFFF;
`else
   // 4*(2^32-1)^2 = 2^66 - 2^35 + 4, whose low 32 bits are 4.
   localparam logic [31:0] c_FULL_EXP = 32'h0000_0004;
`endif

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stream A then B into the pN=4 engine; tlast is raised on beat tlast_beat.
   task automatic send4(input int tlast_beat, input bit gaps);
      int wc;
      for (int b = 0; b < 32; b++) begin
         if (gaps && (b % 5 == 2)) begin
            ss4.tvalid = 1'b0;
            @(posedge clk); #1;
         end
         ss4.tvalid = 1'b1;
         ss4.tdata  = (b < 16) ? a_v[b] : b_v[b-16];
         ss4.tlast  = (b == tlast_beat);
         wc = 0;
         while (!ss4.tready && wc < 100) begin
            @(posedge clk); #1;
            wc++;
         end
         if (wc >= 100) check_eq("ss_tready_timeout", ss4.tready, 1);
         @(posedge clk); #1;
      end
      ss4.tvalid = 1'b0;
      ss4.tlast  = 1'b0;
      ss4.tdata  = '0;
   endtask

   // Collect pN=4 results against e_v; called right after send4 returns.
   task automatic collect4(input bit rnd, input int stop_after);
      int  got, cyc, lat;
      bit  seen;
      got = 0; cyc = 0; lat = 1; seen = 0;
      while (got < stop_after && cyc < 1000) begin
         sm4.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sm4.tvalid) begin
            if (!seen) begin
               check_eq("latency", lat, 17);
               seen = 1;
            end
            check_eq("sm_tdata", sm4.tdata, e_v[got]);
            check_eq("sm_tlast", sm4.tlast, (got == 15));
            if (sm4.tready) got++;
         end else begin
            if (seen) check_eq("sm_tvalid_hold", sm4.tvalid, 1);
            check_eq("sm_tdata_idle", sm4.tdata, 0);
         end
         @(posedge clk); #1;
         cyc++; lat++;
      end
      if (got < stop_after) check_eq("drain_timeout", got, stop_after);
      sm4.tready = 1'b0;
   endtask

   task automatic check_idle4();
      check_eq("busy_after_job", busy4, 0);
      check_eq("sm_tvalid_after_job", sm4.tvalid, 0);
      check_eq("sm_tdata_after_job", sm4.tdata, 0);
   endtask

   initial begin
      rst = 1'b1;
      ss4.tvalid = 1'b0; ss4.tdata = '0; ss4.tlast = 1'b0; sm4.tready = 1'b0;
      ss2.tvalid = 1'b0; ss2.tdata = '0; ss2.tlast = 1'b0; sm2.tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check_eq("rst_ss_tready", ss4.tready, 0);
      check_eq("rst_sm_tvalid", sm4.tvalid, 0);
      check_eq("rst_sm_tlast",  sm4.tlast,  0);
      check_eq("rst_sm_tdata",  sm4.tdata,  0);
      check_eq("rst_busy",      busy4,      0);
      check_eq("rst_err",       err4,       0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("load_after_rst_busy",   busy4,      1);
      check_eq("load_after_rst_tready", ss4.tready, 1);

      // pN=4, A = identity, B = 1..16 -> C = 1..16
      for (int i = 0; i < 16; i++) begin
         a_v[i] = (i / 4 == i % 4) ? 32'd1 : 32'd0;
         b_v[i] = 32'(i + 1);
         e_v[i] = 32'(i + 1);
      end
      send4(31, 1'b0);
      collect4(1'b0, 16);
      check_idle4();
      check_eq("identity_err", err4, 0);

      // pN=2, [[1,2],[3,4]] x [[5,6],[7,8]] -> 19,22,43,50
      v2 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      e2 = '{32'd19, 32'd22, 32'd43, 32'd50};
      for (int b = 0; b < 8; b++) begin
         ss2.tvalid = 1'b1;
         ss2.tdata  = v2[b];
         ss2.tlast  = (b == 7);
         cyc2 = 0;
         while (!ss2.tready && cyc2 < 100) begin
            @(posedge clk); #1;
            cyc2++;
         end
         if (cyc2 >= 100) check_eq("n2_tready_timeout", ss2.tready, 1);
         @(posedge clk); #1;
      end
      ss2.tvalid = 1'b0; ss2.tlast = 1'b0;
      sm2.tready = 1'b1;
      got2 = 0; cyc2 = 0;
      while (got2 < 4 && cyc2 < 200) begin
         if (sm2.tvalid) begin
            check_eq("n2_tdata", sm2.tdata, e2[got2]);
            check_eq("n2_tlast", sm2.tlast, (got2 == 3));
            got2++;
         end
         @(posedge clk); #1;
         cyc2++;
      end
      if (got2 < 4) check_eq("n2_drain_timeout", got2, 4);
      check_eq("n2_err", err2, 0);

      // diag(1,2,3,4) x (1..16), input gaps and random output back-pressure
      for (int i = 0; i < 16; i++) begin
         a_v[i] = (i / 4 == i % 4) ? 32'(i / 4 + 1) : 32'd0;
         b_v[i] = 32'(i + 1);
      end
      e_v = '{32'd1,  32'd2,  32'd3,  32'd4,  32'd10, 32'd12, 32'd14, 32'd16,
              32'd27, 32'd30, 32'd33, 32'd36, 32'd52, 32'd56, 32'd60, 32'd64};
      send4(31, 1'b1);
      collect4(1'b1, 16);
      check_idle4();

      // All elements at full scale: saturate or wrap
      for (int i = 0; i < 16; i++) begin
         a_v[i] = 32'hFFFF_FFFF;
         b_v[i] = 32'hFFFF_FFFF;
         e_v[i] = c_FULL_EXP;
      end
      send4(31, 1'b0);
      collect4(1'b0, 16);
      check_idle4();
      check_eq("clean_jobs_err", err4, 0);

      // Early tlast on beat 10: sticky err, job still completes
      for (int i = 0; i < 16; i++) begin
         a_v[i] = (i / 4 == i % 4) ? 32'd1 : 32'd0;
         b_v[i] = 32'(16 - i);
         e_v[i] = 32'(16 - i);
      end
      send4(10, 1'b0);
      check_eq("framing_err_set", err4, 1);
      collect4(1'b0, 16);
      check_idle4();
      check_eq("framing_err_sticky", err4, 1);

      // Reset pulsed while DRAIN presents beat 5
      for (int i = 0; i < 16; i++) begin
         b_v[i] = 32'(i + 1);
         e_v[i] = 32'(i + 1);
      end
      send4(31, 1'b0);
      collect4(1'b0, 5);
      rst = 1'b1;
      sm4.tready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midrst_sm_tvalid", sm4.tvalid, 0);
      check_eq("midrst_busy",      busy4,      0);
      check_eq("midrst_err",       err4,       0);
      sm4.tready = 1'b0;

      // Fresh job after reset: A = all ones -> column sums of B
      for (int i = 0; i < 16; i++) begin
         a_v[i] = 32'd1;
         e_v[i] = 32'(28 + 4 * (i % 4));
      end
      send4(31, 1'b0);
      collect4(1'b0, 16);
      check_idle4();
      check_eq("post_rst_err", err4, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
